// File: rtl/pipe_wb_arbiter_pkg.sv
// Shared CPU definitions for the writeback arbiter: register/data widths,
// the default starvation limit for requester B, and the grant encoding.
package pipe_wb_arbiter_pkg;

  localparam int unsigned REG_W            = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned NUM_REGS         = 1 << REG_W;
  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Which requester, if any, owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_A,
    GRANT_B
  } grant_e;

endpackage

// File: rtl/pipe_wb_arbiter_if.sv
// Writeback bus: two requesters, the long-latency issue notice, the decode
// source lookup and the registered register-file write port.
interface pipe_wb_arbiter_if;
  import pipe_wb_arbiter_pkg::*;

  logic     a_valid;
  reg_idx_t a_wn;
  data_t    a_d;
  logic     a_ready;

  logic     b_valid;
  reg_idx_t b_wn;
  data_t    b_d;
  logic     b_ready;

  logic     issue_valid;
  reg_idx_t issue_wn;

  reg_idx_t rna;
  reg_idx_t rnb;
  logic     raw_stall;

  reg_idx_t wn;
  data_t    d;
  logic     we;

  // Pipeline / B unit / decode side.
  modport master (
    output a_valid, a_wn, a_d, b_valid, b_wn, b_d,
    output issue_valid, issue_wn, rna, rnb,
    input  a_ready, b_ready, raw_stall, wn, d, we
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_wn, a_d, b_valid, b_wn, b_d,
    input  issue_valid, issue_wn, rna, rnb,
    output a_ready, b_ready, raw_stall, wn, d, we
  );

endinterface

// File: rtl/pipe_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for the multi-cycle unit: one busy bit per
// register (r0 excluded), set at issue, cleared at B writeback, and looked
// up combinationally for the two decode sources.
module pipe_scoreboard
  import pipe_wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     clrn,
  input  logic     set_valid,
  input  reg_idx_t set_wn,
  input  logic     clr_valid,
  input  reg_idx_t clr_wn,
  input  reg_idx_t rna,
  input  reg_idx_t rnb,
  output logic     raw_stall
);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:1] set_mask;
  logic [NUM_REGS-1:1] clr_mask;
  logic [NUM_REGS-1:0] busy_full;

  // Decode set/clear indices to masks and look up both decode sources.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    set_mask  = '0;
    clr_mask  = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      set_mask[i] = set_valid && (set_wn == REG_W'(i));
      clr_mask[i] = clr_valid && (clr_wn == REG_W'(i));
    end
    // r0 reads as never busy, so index 0 needs no special case.
    busy_full = {busy, 1'b0};
    raw_stall = busy_full[rna] | busy_full[rnb];
  end

  // Busy bits: a set on the same edge as a clear of that register wins.
  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: busy is a small flop array rather than a RAM, so it is reset like any other state.
    if (!clrn) begin
      busy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/pipe_wb_arbiter.sv
// Writeback arbiter: the pipeline (A) normally owns the register-file write
// port; the multi-cycle unit (B) takes it when A is idle or after B has been
// refused MAX_WAIT consecutive cycles. The write port is registered.
module pipe_wb_arbiter
  import pipe_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT  // legal 1..7
) (
  input logic              clk,
  input logic              clrn,
  pipe_wb_arbiter_if.slave bus
);

  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

  logic [2:0] wait_cnt;
  logic       b_priority;
  logic       a_ready;
  logic       b_ready;
  logic       a_accept;
  logic       b_accept;
  grant_e     grant;
  reg_idx_t   wn_q;
  data_t      d_q;
  logic       we_q;

  // Arbitration: handshakes are combinational from inputs and wait_cnt.
  always_comb begin
    b_priority = bus.b_valid && (wait_cnt >= WAIT_LIMIT);
    a_ready    = !b_priority;
    // While in reset B is shown ready whenever it is valid.
    b_ready    = bus.b_valid && (!bus.a_valid || b_priority || !clrn);
    a_accept   = bus.a_valid && a_ready;
    b_accept   = bus.b_valid && b_ready;
    grant      = GRANT_NONE;
    if (b_accept) begin
      grant = GRANT_B;
    end else if (a_accept) begin
      grant = GRANT_A;
    end
  end

  // Starvation counter: counts consecutive refused B cycles, saturating at 7.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if (b_accept || !bus.b_valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 3'd7) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // Registered write port; writes to r0 are accepted but never enabled.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wn_q <= '0;
      d_q  <= '0;
      we_q <= 1'b0;
    end else begin
      unique case (grant)
        GRANT_A: begin
          wn_q <= bus.a_wn;
          d_q  <= bus.a_d;
          we_q <= (bus.a_wn != '0);
        end
        GRANT_B: begin
          wn_q <= bus.b_wn;
          d_q  <= bus.b_d;
          we_q <= (bus.b_wn != '0);
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

  pipe_scoreboard u_scoreboard (
    .clk       (clk),
    .clrn      (clrn),
    .set_valid (bus.issue_valid),
    .set_wn    (bus.issue_wn),
    .clr_valid (b_accept),
    .clr_wn    (bus.b_wn),
    .rna       (bus.rna),
    .rnb       (bus.rnb),
    .raw_stall (bus.raw_stall)
  );

  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;
  assign bus.wn      = wn_q;
  assign bus.d       = d_q;
  assign bus.we      = we_q;

endmodule
